// File: rtl/mmio_timer.sv
// Multi-channel prescaled timer/compare peripheral on the LSU MMIO request path.
// Each 16-byte slot holds COUNT, COMPARE, CTRL and STATUS for one channel.
module mmio_timer #(
   parameter int          N_CH      = 4,
   parameter int          CNT_W     = 32,
   parameter int          PSC_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_7800
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [31:0]     i_lsu_addr,
   input  logic [31:0]     i_st_data,
   input  logic [3:0]      i_st_strb,
   input  logic            i_lsu_wren,
   input  logic            i_VALID,
   output logic            o_READY,
   output logic [31:0]     o_ld_data,
   output logic            o_hit,
   output logic [N_CH-1:0] o_irq,
   output logic            o_irq_any
);
   localparam int          CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [31:0] WIN_BYTES = 32'(16 * N_CH);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
   state_t state, state_nxt;

   logic [31:0]      offset;
   logic [31:0]      mask;
   logic [31:0]      rd_val;
   logic [CH_W-1:0]  ch_sel;
   logic [1:0]       reg_sel;
   logic             accept;

   logic [CNT_W-1:0] count_v   [N_CH];
   logic [CNT_W-1:0] compare_v [N_CH];
   logic [31:0]      ctrl_v    [N_CH];
   logic [1:0]       status_v  [N_CH];

   function automatic logic [31:0] byte_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = 32'h0;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
      return m;
   endfunction

   assign offset    = i_lsu_addr - BASE_ADDR;
   assign o_hit     = i_VALID && (offset < WIN_BYTES);
   assign ch_sel    = offset[4 +: CH_W];
   assign reg_sel   = offset[3:2];
   assign mask      = byte_mask(i_st_strb);
   assign accept    = (state == IDLE) && o_hit;
   assign o_irq_any = |o_irq;

   // Read mux: selected register of the addressed channel, unimplemented bits zero.
   always_comb begin
      rd_val = 32'h0;
      case (reg_sel)
         2'd0:    rd_val = 32'(count_v[ch_sel]);
         2'd1:    rd_val = 32'(compare_v[ch_sel]);
         2'd2:    rd_val = ctrl_v[ch_sel];
         2'd3:    rd_val = {30'h0, status_v[ch_sel]};
         default: rd_val = 32'h0;
      endcase
   end

   // Handshake state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: a hit in IDLE is accepted; RESP always lasts one cycle.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    if (o_hit) state_nxt = RESP; else state_nxt = IDLE;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Response strobe decoded straight from the state flop.
   always_comb begin
      if (state == RESP) o_READY = 1'b1;
      else               o_READY = 1'b0;
   end

   // Load data captures the pre-edge register value at the accept edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       o_ld_data <= 32'h0;
      else if (accept) o_ld_data <= rd_val;
      else             o_ld_data <= o_ld_data;
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [CNT_W-1:0] count, compare;
      logic [PSC_W-1:0] psc, psc_cnt;
      logic             en, oneshot, ie, pend, ovf;
      logic             sel, count_wr, compare_wr, ctrl_wr, status_wr;
      logic             tick, fire, match;

      assign sel        = accept && i_lsu_wren && (ch_sel == CH_W'(c));
      assign count_wr   = sel && (reg_sel == 2'd0);
      assign compare_wr = sel && (reg_sel == 2'd1);
      assign ctrl_wr    = sel && (reg_sel == 2'd2);
      assign status_wr  = sel && (reg_sel == 2'd3);
      assign tick       = en && (psc_cnt == psc);
      // A software COUNT write on the tick edge swallows the whole tick.
      assign fire       = tick && !count_wr;
      assign match      = (count == compare);

      assign count_v[c]   = count;
      assign compare_v[c] = compare;
      assign ctrl_v[c]    = (32'(psc) << 16) | {29'h0, ie, oneshot, en};
      assign status_v[c]  = {ovf, pend};
      assign o_irq[c]     = pend & ie;

      // Channel state: prescaler, counter, compare, control and sticky flags.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            count   <= {CNT_W{1'b0}};
            compare <= {CNT_W{1'b0}};
            psc     <= {PSC_W{1'b0}};
            psc_cnt <= {PSC_W{1'b0}};
            en      <= 1'b0;
            oneshot <= 1'b0;
            ie      <= 1'b0;
            pend    <= 1'b0;
            ovf     <= 1'b0;
         end else begin
            if (ctrl_wr || tick || !en) psc_cnt <= {PSC_W{1'b0}};
            else                        psc_cnt <= psc_cnt + PSC_W'(1);

            if (count_wr)
               count <= (count & ~mask[CNT_W-1:0]) | (i_st_data[CNT_W-1:0] & mask[CNT_W-1:0]);
            else if (fire && match && !oneshot)
               count <= {CNT_W{1'b0}};
            else if (fire && !match)
               count <= count + CNT_W'(1);
            else
               count <= count;

            if (compare_wr)
               compare <= (compare & ~mask[CNT_W-1:0]) | (i_st_data[CNT_W-1:0] & mask[CNT_W-1:0]);
            else
               compare <= compare;

            if (ctrl_wr) begin
               en      <= (en & ~mask[0]) | (i_st_data[0] & mask[0]);
               oneshot <= (oneshot & ~mask[1]) | (i_st_data[1] & mask[1]);
               ie      <= (ie & ~mask[2]) | (i_st_data[2] & mask[2]);
               psc     <= (psc & ~mask[16 +: PSC_W]) | (i_st_data[16 +: PSC_W] & mask[16 +: PSC_W]);
            end else if (fire && match && oneshot) begin
               en <= 1'b0;
            end else begin
               en <= en;
            end

            if (fire && match)                             pend <= 1'b1;
            else if (status_wr && i_st_data[0] && mask[0]) pend <= 1'b0;
            else                                           pend <= pend;

            if (fire && !match && (count == {CNT_W{1'b1}})) ovf <= 1'b1;
            else if (status_wr && i_st_data[1] && mask[1])  ovf <= 1'b0;
            else                                            ovf <= ovf;
         end
      end
   end
endmodule

// File: doc/mmio_timer.md
# mmio_timer

Parametrised multi-channel timer/compare peripheral for the RV32I load/store unit's MMIO space. It replaces the fixed four free-running 32-bit timers with N_CH channels, each with a prescaler, compare match, periodic/one-shot mode, overflow flag and maskable interrupt. It sits beside the LEDR/LEDG/SEG7/LCD registers on the LSU's VALID/READY request path and answers accesses in its own address window with a registered two-cycle handshake.

## Interface
- N_CH, 4: channel count; power of two, 1..8
- CNT_W, 32: counter/compare width, 8..32
- PSC_W, 16: prescaler width, 1..16
- BASE_ADDR, 32'h0000_7800: window base; aligned to 16*N_CH bytes

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_lsu_addr  in  32  byte address
- i_st_data  in  32  store data
- i_st_strb  in  4  byte strobes for writes
- i_lsu_wren  in  1  1 = write
- i_VALID  in  1  request valid; held by requester until o_READY
- o_READY  out  1  one-cycle response strobe
- o_ld_data  out  32  read data, valid while o_READY
- o_hit  out  1  combinational: i_VALID and address inside window
- o_irq  out  N_CH  per-channel interrupt, PEND & IE
- o_irq_any  out  1  OR of o_irq

## Operation
- Window: 16*N_CH bytes from BASE_ADDR; channel = addr[4+log2(N_CH)-1:4], register = addr[3:2], addr[1:0] ignored.
- Per-channel registers (offset ch*16): +0 COUNT (RW, CNT_W bits); +4 COMPARE (RW, CNT_W bits); +8 CTRL: [0] EN, [1] ONESHOT, [2] IE, [16+:PSC_W] PSC; +C STATUS: [0] PEND, [1] OVF, both write-1-to-clear. Unimplemented bits read 0, writes ignored.
- Writes merge per byte: reg = (reg & ~mask) | (data & mask), mask from i_st_strb; for STATUS only strobed bytes with 1s clear bits.
- Prescaler: per channel psc_cnt (PSC_W); while EN, increments each cycle; when psc_cnt == PSC, psc_cnt <= 0 and a tick occurs. PSC=0 ticks every cycle. Any CTRL write resets psc_cnt to 0; EN=0 holds psc_cnt at 0.
- On tick: if COUNT == COMPARE -> PEND <= 1; periodic: COUNT <= 0; one-shot: COUNT holds, EN <= 0. Else COUNT <= COUNT+1; if COUNT was all-ones, wraps to 0 and OVF <= 1.
- FSM: IDLE, RESP. IDLE with o_hit: capture register value into o_ld_data (pre-edge value), perform write at same edge, go RESP. RESP: o_READY=1, -> IDLE unconditionally; i_VALID ignored in RESP.
- No hit: no state change, o_READY stays 0 (other LSU peripherals respond).

## Timing
- Reset (async, any cycle, including RESP): FSM IDLE, o_READY 0, o_ld_data 0, all COUNT/COMPARE/CTRL/STATUS/psc_cnt 0, o_irq 0.
- Latency: accept edge -> o_READY high the next cycle, for exactly one cycle; back-to-back requests accepted every 2 cycles.
- Write effect visible from the cycle after the accept edge; o_irq is registered-derived (same cycle as PEND).
- Simultaneous software write to COUNT and tick on same edge: write wins, tick dropped.
- W1C of PEND/OVF on same edge as hardware set: set wins.
- Write EN=1 with COUNT == COMPARE: match on first tick, PSC+1 cycles later.
- Read of COUNT returns value before same-edge increment.

## Test plan
- Reset mid-RESP: assert i_rst during o_READY -> o_READY 0 immediately, all reads afterwards 0.
- Ch0 COMPARE=3, CTRL=EN (PSC=0, periodic) -> PEND set 4 cycles after write completes, COUNT sequence 0,1,2,3,0; IE=1 -> o_irq[0]=1, o_irq_any=1; write STATUS=1 -> cleared.
- Ch1 CTRL=EN|ONESHOT|PSC=2, COMPARE=2 -> COUNT increments every 3 cycles, PEND after 9 cycles, EN reads 0, COUNT holds 2.
- Ch2 COUNT=CNT_W'(all ones), COMPARE=5, EN -> next tick COUNT=0, OVF=1, PEND 0.
- Byte write: COMPARE=32'h11223344 then strb 4'b0100 data 32'h00AA0000 -> reads 32'h11AA3344; read back takes 2 cycles, o_READY one-cycle pulse.
- Address 8 bytes past window end and write with i_VALID -> o_hit 0, o_READY 0, no register changes.
